// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field-bundle handshake plus instruction-memory write port
interface inst_encoder_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into instruction words and streams them to instruction memory
module inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inst_encoder_if.slave     b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic              wrap;
  logic [31:0]       im, word;
  logic [2:0]        f, chk;
  logic              s11, s12, s20, rng, accept, complete, go;
  assign im       = b.in_imm;
  assign f        = b.in_fmt;
  assign busy     = state == RUN || state == FLUSH;
  assign done     = state == DONE;
  assign b.in_ready = state == RUN && (!b.mem_we || b.mem_ready);
  assign accept   = b.in_valid && b.in_ready;
  assign complete = b.mem_we && b.mem_ready;
  assign go       = start && (state == IDLE || state == DONE);
  assign s11 = &im[31:11] || ~|im[31:11];
  assign s12 = &im[31:12] || ~|im[31:12];
  assign s20 = &im[31:20] || ~|im[31:20];
  assign rng = (f == 3'd1 || f == 3'd2) ? !s11 :
               f == 3'd3 ? !s12 :
               f == 3'd5 ? !s20 :
               f == 3'd4 ? |im[11:0] : 1'b0;
  assign chk = (f == 3'd6 || f == 3'd7) ? 3'd3 :
               wrap ? 3'd4 :
               ((f == 3'd3 || f == 3'd5) && im[0]) ? 3'd2 :
               rng ? 3'd1 : 3'd0;
  always_comb begin
    word = '0;
    case (f)
      3'd0: word = {b.in_funct7, b.in_rs2, b.in_rs1, b.in_funct3, b.in_rd, b.in_opcode};
      3'd1: word = {im[11:0], b.in_rs1, b.in_funct3, b.in_rd, b.in_opcode};
      3'd2: word = {im[11:5], b.in_rs2, b.in_rs1, b.in_funct3, im[4:0], b.in_opcode};
      3'd3: word = {im[12], im[10:5], b.in_rs2, b.in_rs1, b.in_funct3, im[4:1], im[11], b.in_opcode};
      3'd4: word = {im[31:12], b.in_rd, b.in_opcode};
      3'd5: word = {im[20], im[10:1], im[11], im[19:12], b.in_rd, b.in_opcode};
      default: word = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN:        if (accept && (chk != 3'd0 || b.in_last)) state_n = FLUSH;
      FLUSH:      if (!b.mem_we || b.mem_ready) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      ptr         <= ADDR_W'(BASE_ADDR);
      wrap        <= 1'b0;
      b.mem_we    <= 1'b0;
      b.mem_addr  <= ADDR_W'(BASE_ADDR);
      b.mem_wdata <= '0;
      err         <= 1'b0;
      err_code    <= '0;
      count       <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        ptr      <= ADDR_W'(BASE_ADDR);
        wrap     <= 1'b0;
        err      <= 1'b0;
        err_code <= '0;
        count    <= '0;
      end else begin
        if (complete) begin
          count    <= count + 1'b1;
          b.mem_we <= 1'b0;
        end
        if (accept && chk == 3'd0) begin
          b.mem_we    <= 1'b1;
          b.mem_addr  <= ptr;
          b.mem_wdata <= word;
          ptr         <= ptr + 1'b1;
          if (&ptr) wrap <= 1'b1;
        end
        if (accept && chk != 3'd0 && !err) begin
          err      <= 1'b1;
          err_code <= chk;
        end
      end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vectors against hand-encoded RV32I words and an immediate decoder
module tb_inst_encoder;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, err;
  logic [2:0] err_code;
  logic [2:0] count;
  int checks = 0, errors = 0;
  inst_encoder_if #(.ADDR_W(2)) bus();
  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .b(bus),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end
  function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1: dec_imm = {{20{w[31]}}, w[31:20]};
      3'd2: dec_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: dec_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: dec_imm = {w[31:12], 12'b0};
      3'd5: dec_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                     input logic last);
    bus.in_fmt = f; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1;
  endtask
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic last);
    drv(f, op, rd, rs1, rs2, f3, f7, imm, last);
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) begin @(posedge clk); #1; end
    check("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 0; bus.in_last = 0;
  endtask
  task automatic expw(input string tag, input logic [2:0] f, input logic [31:0] imm, input int a, input logic [31:0] w);
    check({tag, "_we"}, bus.mem_we, 1);
    check({tag, "_addr"}, bus.mem_addr, a);
    check({tag, "_word"}, bus.mem_wdata, w);
    if (f != 3'd0) check({tag, "_imm_roundtrip"}, dec_imm(f, bus.mem_wdata), imm);
  endtask
  task automatic go();
    start = 1; @(posedge clk); #1; start = 0;
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    check("start_err_code", err_code, 0);
    check("start_count", count, 0);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.mem_ready = 1;
    bus.in_fmt = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_imm = 0;
    #2;
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_count", count, 0);
    #10 rst = 0;
    drv(1, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
    tick(); tick();
    bus.in_valid = 0;
    check("idle_valid_we", bus.mem_we, 0);
    check("idle_valid_busy", busy, 0);
    go();
    check("run_ready", bus.in_ready, 1);
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
    expw("addi", 1, 32'hFFFFFFFF, 0, 32'hFFF00093);
    send(3, 7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 1);
    expw("beq", 3, 32'hFFFFFFFC, 1, 32'hFE208EE3);
    check("beq_count", count, 1);
    tick();
    check("rt_done", done, 1);
    check("rt_count", count, 2);
    check("rt_err", err, 0);
    check("rt_we", bus.mem_we, 0);
    go();
    send(0, 7'h33, 3, 1, 2, 0, 0, 32'h0, 0);
    expw("add", 0, 32'h0, 0, 32'h002081B3);
    send(2, 7'h23, 0, 1, 2, 2, 0, 32'h8, 0);
    expw("sw", 2, 32'h8, 1, 32'h0020A423);
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000, 0);
    expw("lui", 4, 32'h12345000, 2, 32'h123452B7);
    send(5, 7'h6F, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 1);
    expw("jal", 5, 32'hFFFFFFF8, 3, 32'hFF9FF0EF);
    tick();
    check("fmt_done", done, 1);
    check("fmt_count", count, 4);
    go();
    send(5, 7'h6F, 0, 0, 0, 0, 0, 32'h800, 0);
    expw("jal_b11", 5, 32'h800, 0, 32'h0010006F);
    send(3, 7'h63, 0, 0, 0, 0, 0, 32'h800, 0);
    expw("b_b11", 3, 32'h800, 1, 32'h000000E3);
    send(5, 7'h6F, 0, 0, 0, 0, 0, 32'h1000, 0);
    expw("jal_b12", 5, 32'h1000, 2, 32'h0000106F);
    send(1, 7'h13, 0, 0, 0, 0, 0, 32'hFFFFF800, 1);
    expw("i_min", 1, 32'hFFFFF800, 3, 32'h80000013);
    tick();
    check("swz_done", done, 1);
    go();
    bus.mem_ready = 0;
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
    expw("stall_wr", 1, 32'hFFFFFFFF, 0, 32'hFFF00093);
    drv(1, 7'h13, 2, 0, 0, 0, 0, 32'h5, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_we", bus.mem_we, 1);
      check("stall_addr", bus.mem_addr, 0);
      check("stall_word", bus.mem_wdata, 32'hFFF00093);
      check("stall_ready", bus.in_ready, 0);
      check("stall_count", count, 0);
    end
    bus.mem_ready = 1;
    tick();
    bus.in_valid = 0; bus.in_last = 0;
    expw("stall_next", 1, 32'h5, 1, 32'h00500113);
    check("stall_release_count", count, 1);
    tick();
    check("stall_done", done, 1);
    check("stall_final_count", count, 2);
    go();
    bus.mem_ready = 0;
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
    expw("pend_wr", 1, 32'h1, 0, 32'h00100093);
    drv(7, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
    tick();
    check("pend_ready", bus.in_ready, 0);
    bus.mem_ready = 1;
    tick();
    bus.in_valid = 0;
    check("pend_we", bus.mem_we, 0);
    check("pend_count", count, 1);
    check("pend_err", err, 1);
    check("pend_err_code", err_code, 3);
    check("pend_busy", busy, 1);
    tick();
    check("pend_done", done, 1);
    check("pend_final_count", count, 1);
    check("pend_final_code", err_code, 3);
    go();
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048, 0);
    check("rng_we", bus.mem_we, 0);
    check("rng_err", err, 1);
    check("rng_err_code", err_code, 1);
    check("rng_done_early", done, 0);
    tick();
    check("rng_done", done, 1);
    check("rng_count", count, 0);
    go();
    send(5, 7'h6F, 1, 0, 0, 0, 0, 32'h3, 0);
    check("mis_err_code", err_code, 2);
    check("mis_we", bus.mem_we, 0);
    tick();
    check("mis_done", done, 1);
    go();
    send(3, 7'h63, 0, 1, 2, 0, 0, 32'h1000, 0);
    check("brng_err_code", err_code, 1);
    tick();
    check("brng_done", done, 1);
    go();
    for (int k = 0; k < 4; k++) begin
      send(1, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
      expw("ovf_wr", 1, 32'h1, k, 32'h00100093);
    end
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
    check("ovf_err", err, 1);
    check("ovf_err_code", err_code, 4);
    check("ovf_count", count, 4);
    check("ovf_we", bus.mem_we, 0);
    tick();
    check("ovf_done", done, 1);
    go();
    bus.mem_ready = 0;
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'h1, 0);
    expw("rstm_wr", 1, 32'h1, 0, 32'h00100093);
    #2 rst = 1;
    #1;
    check("rstm_we", bus.mem_we, 0);
    check("rstm_busy", busy, 0);
    check("rstm_done", done, 0);
    check("rstm_ready", bus.in_ready, 0);
    check("rstm_addr", bus.mem_addr, 0);
    check("rstm_count", count, 0);
    #3 rst = 0;
    bus.mem_ready = 1;
    go();
    send(1, 7'h13, 2, 0, 0, 0, 0, 32'h5, 1);
    expw("rstm_again", 1, 32'h5, 0, 32'h00500113);
    tick();
    check("rstm_again_done", done, 1);
    check("rstm_again_count", count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
